spi_reg_bridge: RTL and testbench

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

---
 rtl/spi_reg_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge
//   Turns the byte stream of an upstream SPI slave into register-bus
//   accesses. A frame is a command byte {rw, addr[6:0]} followed by 16-bit
//   words, high byte first. Writes issue one reg_wr_en per completed word.
//   Reads prefetch each word so that its bytes are ready on tx_data in time
//   for the next exchanges.
//
// Ports
//   sys_clk    : clock, all logic on the rising edge
//   sys_rst    : asynchronous active-high reset
//   cs         : chip select, active low, already synchronous; high ends a frame
//   rx_valid   : one-cycle strobe, one byte exchanged
//   rx_data    : received byte, valid with rx_valid
//   tx_data    : byte the SPI slave loads for the next exchange
//   reg_addr   : register address
//   reg_wdata  : register write data
//   reg_wr_en  : one-cycle write strobe
//   reg_rd_en  : one-cycle read strobe
//   reg_rdata  : read data, valid one cycle after reg_rd_en
//   frame_err  : one-cycle pulse when a frame ends between the two bytes of a word
//   busy       : high whenever the FSM is not idle
module spi_reg_bridge #(
  parameter logic       AUTO_INC = 1'b1,
  parameter logic [7:0] IDLE_TX  = 8'hA5
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cs,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [7:0]  tx_data,
  output logic [6:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  input  logic [15:0] reg_rdata,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_HI   = 2'd2,
    ST_LO   = 2'd3
  } state_t;

  state_t      state_q, state_d;

  // armed_q is set once cs has been seen high since reset, so a frame that
  // was already in progress when reset released is never picked up halfway.
  logic        armed_q, armed_d;
  logic        rw_q, rw_d;
  logic [7:0]  hi_buf_q, hi_buf_d;
  logic [15:0] rd_buf_q, rd_buf_d;
  logic [7:0]  tx_q, tx_d;
  logic [6:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_en_q, rd_en_d;
  // High in the cycle reg_rdata carries the answer to the last read strobe.
  logic        rd_cap_q, rd_cap_d;
  logic        frame_err_q, frame_err_d;

  // A byte only counts while the frame is still open; cs high wins.
  logic        byte_ok;
  assign byte_ok = rx_valid & ~cs;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    armed_d = armed_q | cs;
    if (cs) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (armed_q)  state_d = ST_CMD;
        ST_CMD:  if (rx_valid) state_d = ST_HI;
        ST_HI:   if (rx_valid) state_d = ST_LO;
        ST_LO:   if (rx_valid) state_d = ST_HI;
        default:               state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------
  always_comb begin
    rw_d        = rw_q;
    hi_buf_d    = hi_buf_q;
    rd_buf_d    = rd_buf_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    // A read answer arriving after the frame closed is a stale prefetch.
    rd_cap_d    = rd_en_q & ~cs;
    frame_err_d = cs & (state_q == ST_LO);

    // The address steps once per issued strobe, after the strobe cycle, so
    // the strobe itself always shows the address of the word it belongs to.
    if (state_q == ST_CMD && byte_ok) begin
      addr_d = rx_data[6:0];
    end else if ((wr_en_q || rd_en_q) && AUTO_INC) begin
      addr_d = addr_q + 7'd1;
    end

    case (state_q)
      ST_CMD: begin
        if (byte_ok) begin
          rw_d    = rx_data[7];
          rd_en_d = rx_data[7];
          tx_d    = IDLE_TX;
        end
      end
      ST_HI: begin
        if (byte_ok) begin
          hi_buf_d = rx_data;
          if (rw_q) tx_d = rd_buf_q[7:0];
        end
      end
      ST_LO: begin
        if (byte_ok) begin
          if (rw_q) begin
            // Word complete: prefetch the next one.
            rd_en_d = 1'b1;
          end else begin
            wr_en_d = 1'b1;
            wdata_d = {hi_buf_q, rx_data};
          end
        end
      end
      default: ;
    endcase

    if (rd_cap_q && !cs) begin
      rd_buf_d = reg_rdata;
      tx_d     = reg_rdata[15:8];
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rw_q        <= 1'b0;
      hi_buf_q    <= 8'h00;
      rd_buf_q    <= 16'h0000;
      tx_q        <= IDLE_TX;
      addr_q      <= 7'h00;
      wdata_q     <= 16'h0000;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_cap_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rw_q        <= rw_d;
      hi_buf_q    <= hi_buf_d;
      rd_buf_q    <= rd_buf_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      rd_cap_q    <= rd_cap_d;
      frame_err_q <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    busy      = (state_q != ST_IDLE);
    // Read data only reaches the pins inside the word phase of a read frame.
    tx_data   = ((state_q == ST_HI || state_q == ST_LO) && rw_q) ? tx_q : IDLE_TX;
    reg_addr  = addr_q;
    reg_wdata = wdata_q;
    reg_wr_en = wr_en_q;
    reg_rd_en = rd_en_q;
    frame_err = frame_err_q;
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: table of single-word write frames plus
// hand-written sequences for burst read, address wrap, aborts and reset.
module tb_spi_reg_bridge;

  localparam int GAP = 7;

  logic        sys_clk;
  logic        sys_rst;
  logic        cs;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [7:0]  tx_data;
  logic [6:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [15:0] reg_rdata;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [128];
  logic [6:0]  wr_addr_q [$];
  logic [15:0] wr_data_q [$];
  logic [6:0]  rd_addr_q [$];
  int          ferr_cnt = 0;
  int          both_cnt = 0;

  spi_reg_bridge #(.AUTO_INC(1'b1), .IDLE_TX(8'hA5)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .cs       (cs),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_data  (tx_data),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wr_en(reg_wr_en),
    .reg_rd_en(reg_rd_en),
    .reg_rdata(reg_rdata),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Register file answering reads one cycle after the strobe.
  always @(posedge sys_clk) begin
    if (reg_rd_en) reg_rdata <= mem[reg_addr];
  end

  // Strobe monitor.
  always @(negedge sys_clk) begin
    if (reg_wr_en) begin
      wr_addr_q.push_back(reg_addr);
      wr_data_q.push_back(reg_wdata);
      $display("  wr strobe addr=%h data=%h", reg_addr, reg_wdata);
    end
    if (reg_rd_en) begin
      rd_addr_q.push_back(reg_addr);
      $display("  rd strobe addr=%h", reg_addr);
    end
    if (frame_err) ferr_cnt++;
    if (reg_wr_en && reg_rd_en) both_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    ferr_cnt = 0;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge sys_clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge sys_clk);
    rx_valid = 1'b0;
    $display("byte %h", b);
    repeat (GAP) @(negedge sys_clk);
  endtask

  task automatic cs_low();
    @(negedge sys_clk);
    cs = 1'b0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic cs_high();
    @(negedge sys_clk);
    cs = 1'b1;
    repeat (3) @(negedge sys_clk);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [6:0]  exp_addr;
    logic [15:0] exp_wdata;
  } wr_vec_t;

  wr_vec_t vecs [4];

  initial begin
    vecs[0] = '{cmd: 8'h12, hi: 8'hBE, lo: 8'hEF, exp_addr: 7'h12, exp_wdata: 16'hBEEF};
    vecs[1] = '{cmd: 8'h00, hi: 8'h00, lo: 8'h01, exp_addr: 7'h00, exp_wdata: 16'h0001};
    vecs[2] = '{cmd: 8'h55, hi: 8'hFF, lo: 8'hFF, exp_addr: 7'h55, exp_wdata: 16'hFFFF};
    vecs[3] = '{cmd: 8'h7E, hi: 8'h80, lo: 8'h00, exp_addr: 7'h7E, exp_wdata: 16'h8000};

    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    mem[5] = 16'h1234;
    mem[6] = 16'h5678;
    mem[7] = 16'h9ABC;
    reg_rdata = 16'h0000;

    sys_rst  = 1'b1;
    cs       = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge sys_clk);
    check("rst_tx", tx_data, 8'hA5);
    check("rst_addr", reg_addr, 7'h00);
    check("rst_wdata", reg_wdata, 16'h0000);
    check("rst_wr_en", reg_wr_en, 1'b0);
    check("rst_rd_en", reg_rd_en, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Single-word write frames.
    for (int i = 0; i < 4; i++) begin
      $display("write frame cmd=%h word=%h%h", vecs[i].cmd, vecs[i].hi, vecs[i].lo);
      clear_mon();
      cs_low();
      check("wr_busy", busy, 1'b1);
      send(vecs[i].cmd);
      check("wr_tx_idle", tx_data, 8'hA5);
      send(vecs[i].hi);
      send(vecs[i].lo);
      check("wr_tx_idle2", tx_data, 8'hA5);
      cs_high();
      check("wr_count", wr_addr_q.size(), 1);
      check("wr_addr", (wr_addr_q.size() > 0) ? wr_addr_q[0] : 7'bx, vecs[i].exp_addr);
      check("wr_wdata", (wr_data_q.size() > 0) ? wr_data_q[0] : 16'bx, vecs[i].exp_wdata);
      check("wr_ferr", ferr_cnt, 0);
      check("wr_rd_none", rd_addr_q.size(), 0);
      check("wr_addr_inc", reg_addr, vecs[i].exp_addr + 7'd1);
      check("wr_busy_end", busy, 1'b0);
    end

    // Burst read of two words from address 5.
    $display("read burst cmd=85");
    clear_mon();
    cs_low();
    send(8'h85);
    check("rd_tx0", tx_data, 8'h12);
    send(8'h00);
    check("rd_tx1", tx_data, 8'h34);
    send(8'h00);
    check("rd_tx2", tx_data, 8'h56);
    send(8'h00);
    check("rd_tx3", tx_data, 8'h78);
    send(8'h00);
    cs_high();
    check("rd_count", rd_addr_q.size(), 3);
    check("rd_addr0", (rd_addr_q.size() > 0) ? rd_addr_q[0] : 7'bx, 7'h05);
    check("rd_addr1", (rd_addr_q.size() > 1) ? rd_addr_q[1] : 7'bx, 7'h06);
    check("rd_addr2", (rd_addr_q.size() > 2) ? rd_addr_q[2] : 7'bx, 7'h07);
    check("rd_no_wr", wr_addr_q.size(), 0);
    check("rd_tx_end", tx_data, 8'hA5);
    check("rd_ferr", ferr_cnt, 0);

    // Address wrap on a two-word write burst.
    $display("wrap burst cmd=7F");
    clear_mon();
    cs_low();
    send(8'h7F);
    send(8'hBE);
    send(8'hEF);
    send(8'h11);
    send(8'h22);
    cs_high();
    check("wrap_count", wr_addr_q.size(), 2);
    check("wrap_addr0", (wr_addr_q.size() > 0) ? wr_addr_q[0] : 7'bx, 7'h7F);
    check("wrap_data0", (wr_data_q.size() > 0) ? wr_data_q[0] : 16'bx, 16'hBEEF);
    check("wrap_addr1", (wr_addr_q.size() > 1) ? wr_addr_q[1] : 7'bx, 7'h00);
    check("wrap_data1", (wr_data_q.size() > 1) ? wr_data_q[1] : 16'bx, 16'h1122);

    // Abort between the bytes of a word.
    $display("abort cmd=03 byte=AA");
    clear_mon();
    cs_low();
    send(8'h03);
    send(8'hAA);
    @(negedge sys_clk);
    cs = 1'b1;
    @(negedge sys_clk);
    check("abort_ferr_hi", frame_err, 1'b1);
    check("abort_busy", busy, 1'b0);
    @(negedge sys_clk);
    check("abort_ferr_lo", frame_err, 1'b0);
    repeat (3) @(negedge sys_clk);
    check("abort_no_wr", wr_addr_q.size(), 0);
    check("abort_ferr_cnt", ferr_cnt, 1);

    // Frame ended after a complete command byte: not an error.
    $display("clean end in ST_HI cmd=10");
    clear_mon();
    cs_low();
    send(8'h10);
    cs_high();
    check("hi_end_ferr", ferr_cnt, 0);
    check("hi_end_no_wr", wr_addr_q.size(), 0);

    // Byte and cs rise in the same cycle while in ST_LO.
    $display("collision cmd=04 byte=11");
    clear_mon();
    cs_low();
    send(8'h04);
    send(8'h11);
    @(negedge sys_clk);
    cs       = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h22;
    @(negedge sys_clk);
    rx_valid = 1'b0;
    check("coll_ferr_hi", frame_err, 1'b1);
    repeat (3) @(negedge sys_clk);
    check("coll_no_wr", wr_addr_q.size(), 0);
    check("coll_ferr_cnt", ferr_cnt, 1);

    // Reset in the middle of a write burst.
    $display("reset mid-burst cmd=20");
    cs_low();
    send(8'h20);
    send(8'hAB);
    send(8'hCD);
    send(8'hEF);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    clear_mon();
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_addr", reg_addr, 7'h00);
    check("mid_rst_wdata", reg_wdata, 16'h0000);
    check("mid_rst_tx", tx_data, 8'hA5);
    check("mid_rst_wr", reg_wr_en, 1'b0);
    check("mid_rst_rd", reg_rd_en, 1'b0);
    check("mid_rst_ferr", frame_err, 1'b0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    send(8'h01);
    repeat (3) @(negedge sys_clk);
    check("post_rst_no_wr", wr_addr_q.size(), 0);
    check("post_rst_busy", busy, 1'b0);
    cs_high();
    cs_low();
    check("rearm_busy", busy, 1'b1);
    cs_high();
    check("rearm_idle", busy, 1'b0);

    check("strobe_exclusive", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
